ycbcr2rgb_pipe: RTL and testbench



---
 rtl/ycbcr2rgb_pkg.sv | 27 ++
 rtl/ycbcr2rgb_pipe_rgb_clip_round.sv | 20 ++
 rtl/ycbcr2rgb_pipe.sv | 142 ++++++++++++++
 tb/tb_ycbcr2rgb_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ycbcr2rgb_pkg.sv
// ycbcr2rgb_pkg: mode encoding, colour matrix coefficients and offset helpers
package ycbcr2rgb_pkg;
  typedef enum logic [1:0] {
    BT601_LIM  = 2'b00,
    BT709_LIM  = 2'b01,
    BT601_FULL = 2'b10,
    BT709_FULL = 2'b11
  } mode_e;
  localparam int COEF_Q10 [4][5] = '{
    '{1192, 1634, 833, 401, 2065},
    '{1192, 1836, 546, 218, 2163},
    '{1024, 1436, 731, 352, 1815},
    '{1024, 1613, 479, 192, 1900}
  };
  function automatic int scale_coef(input int c, input int frac);
    return frac >= 10 ? c <<< (frac - 10) : (c + (1 <<< (9 - frac))) >>> (10 - frac);
  endfunction
  function automatic int coef(input mode_e m, input int k, input int frac);
    return scale_coef(COEF_Q10[m][k], frac);
  endfunction
  function automatic int yoff(input int in_w, input mode_e m);
    return m[1] ? 0 : 16 << (in_w - 8);
  endfunction
  function automatic int mid(input int in_w);
    return 1 << (in_w - 1);
  endfunction
endpackage

// File: rtl/ycbcr2rgb_pipe_rgb_clip_round.sv
// rgb_clip_round: round-half-up, arithmetic shift and saturate one colour channel
module rgb_clip_round #(
  parameter int W     = 24,
  parameter int SH    = 12,
  parameter int OUT_W = 8
) (
  input  logic signed [W-1:0] v,
  output logic [OUT_W-1:0]    q,
  output logic                clip
);
  localparam logic signed [W-1:0] HALF = W'(1) << (SH - 1);
  localparam logic signed [W-1:0] MAXV = W'((1 << OUT_W) - 1);
  logic signed [W-1:0] t;
  logic neg, over;
  assign t    = (v + HALF) >>> SH;
  assign neg  = t[W-1];
  assign over = !neg && (t > MAXV);
  assign q    = neg ? '0 : over ? '1 : t[OUT_W-1:0];
  assign clip = neg || over;
endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe: 3-stage stream YCbCr to RGB converter with frame-aligned mode and clip count
module ycbcr2rgb_pipe
  import ycbcr2rgb_pkg::*;
#(
  parameter int IN_W      = 10,
  parameter int OUT_W     = 8,
  parameter int COEF_FRAC = 10,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_y,
  input  logic [IN_W-1:0]  s_cb,
  input  logic [IN_W-1:0]  s_cr,
  input  logic             s_sof,
  input  logic             s_eol,
  input  logic [1:0]       mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_r,
  output logic [OUT_W-1:0] m_g,
  output logic [OUT_W-1:0] m_b,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_clip,
  output logic [CNT_W-1:0] clip_cnt
);
  localparam int W  = IN_W + COEF_FRAC + 4;
  localparam int SH = COEF_FRAC + IN_W - OUT_W;
  if (OUT_W > IN_W) begin : g_width_check
    $error("OUT_W must not exceed IN_W");
  end
  logic en;
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  mode_e act_mode, sel_mode, s1_mode;
  logic s1_valid, s1_sof, s1_eol;
  logic [IN_W-1:0] s1_y, s1_cb, s1_cr;
  // a valid sof beat switches the matrix for itself and the rest of the frame
  assign sel_mode = (s_valid && s_sof) ? mode_e'(mode) : act_mode;
  // S1: capture samples and the matrix selection for this pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_mode <= BT601_LIM;
      s1_mode  <= BT601_LIM;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_y     <= '0;
      s1_cb    <= '0;
      s1_cr    <= '0;
    end else if (en) begin
      act_mode <= sel_mode;
      s1_mode  <= sel_mode;
      s1_valid <= s_valid;
      s1_sof   <= s_sof;
      s1_eol   <= s_eol;
      s1_y     <= s_y;
      s1_cb    <= s_cb;
      s1_cr    <= s_cr;
    end
  end
  logic signed [W-1:0] dy, du, dv, k_y, k_rv, k_gv, k_gu, k_bu;
  assign dy   = W'(s1_y) - W'(yoff(IN_W, s1_mode));
  assign du   = W'(s1_cb) - W'(mid(IN_W));
  assign dv   = W'(s1_cr) - W'(mid(IN_W));
  assign k_y  = W'(coef(s1_mode, 0, COEF_FRAC));
  assign k_rv = W'(coef(s1_mode, 1, COEF_FRAC));
  assign k_gv = W'(coef(s1_mode, 2, COEF_FRAC));
  assign k_gu = W'(coef(s1_mode, 3, COEF_FRAC));
  assign k_bu = W'(coef(s1_mode, 4, COEF_FRAC));
  logic s2_valid, s2_sof, s2_eol;
  logic signed [W-1:0] s2_x, s2_rv, s2_gv, s2_gu, s2_bu;
  // S2: offset-removed samples times the selected coefficients
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_x     <= '0;
      s2_rv    <= '0;
      s2_gv    <= '0;
      s2_gu    <= '0;
      s2_bu    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_x     <= dy * k_y;
      s2_rv    <= dv * k_rv;
      s2_gv    <= dv * k_gv;
      s2_gu    <= du * k_gu;
      s2_bu    <= du * k_bu;
    end
  end
  logic signed [W-1:0] r_sum, g_sum, b_sum;
  logic [OUT_W-1:0] r_q, g_q, b_q;
  logic r_c, g_c, b_c;
  assign r_sum = s2_x + s2_rv;
  assign g_sum = s2_x - s2_gv - s2_gu;
  assign b_sum = s2_x + s2_bu;
  rgb_clip_round #(.W(W), .SH(SH), .OUT_W(OUT_W)) u_r (.v(r_sum), .q(r_q), .clip(r_c));
  rgb_clip_round #(.W(W), .SH(SH), .OUT_W(OUT_W)) u_g (.v(g_sum), .q(g_q), .clip(g_c));
  rgb_clip_round #(.W(W), .SH(SH), .OUT_W(OUT_W)) u_b (.v(b_sum), .q(b_q), .clip(b_c));
  // S3: register the rounded, saturated pixel as the output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_r     <= '0;
      m_g     <= '0;
      m_b     <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_clip  <= 1'b0;
    end else if (en) begin
      m_valid <= s2_valid;
      m_r     <= r_q;
      m_g     <= g_q;
      m_b     <= b_q;
      m_sof   <= s2_sof;
      m_eol   <= s2_eol;
      m_clip  <= r_c || g_c || b_c;
    end
  end
  logic [CNT_W-1:0] run_cnt;
  // count clipped output beats per frame; publish the total when the next frame starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      clip_cnt <= '0;
    end else if (m_valid && m_ready) begin
      if (m_sof) begin
        clip_cnt <= run_cnt;
        run_cnt  <= CNT_W'(m_clip);
      end else if (m_clip && run_cnt != '1) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// tb_ycbcr2rgb_pipe: random and directed scoreboard bench for ycbcr2rgb_pipe
module tb_ycbcr2rgb_pipe;
  localparam int IN_W = 10, OUT_W = 8, CNT_W = 16;
  localparam int TBL [4][5] = '{
    '{1192, 1634, 833, 401, 2065},
    '{1192, 1836, 546, 218, 2163},
    '{1024, 1436, 731, 352, 1815},
    '{1024, 1613, 479, 192, 1900}
  };
  logic clk = 1'b0, rst = 1'b1;
  logic s_valid = 1'b0, s_ready, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
  logic m_valid, m_sof, m_eol, m_clip;
  logic [IN_W-1:0] s_y = '0, s_cb = '0, s_cr = '0;
  logic [1:0] mode = 2'b00;
  logic [OUT_W-1:0] m_r, m_g, m_b;
  logic [CNT_W-1:0] clip_cnt;
  always #5 clk = ~clk;
  ycbcr2rgb_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_y(s_y), .s_cb(s_cb),
    .s_cr(s_cr), .s_sof(s_sof), .s_eol(s_eol), .mode(mode), .m_valid(m_valid),
    .m_ready(m_ready), .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_sof(m_sof), .m_eol(m_eol),
    .m_clip(m_clip), .clip_cnt(clip_cnt)
  );
  typedef struct {int r; int g; int b; bit sof; bit eol; bit clip;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  int act_mode = 0, run_m = 0, cnt_m = 0;
  bit stall_en = 1'b0, hold = 1'b0;
  int held = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int sat8(input int v, output bit c);
    int t;
    t = (v + 2048) >>> 12;
    c = (t < 0) || (t > 255);
    return t < 0 ? 0 : t > 255 ? 255 : t;
  endfunction
  function automatic exp_t ref_px(input int y, input int cb, input int cr, input int m,
                                  input bit sof, input bit eol);
    exp_t o;
    bit cr_c, cg_c, cb_c;
    int x;
    x = TBL[m][0] * (y - (m >= 2 ? 0 : 64));
    o.r = sat8(x + TBL[m][1] * (cr - 512), cr_c);
    o.g = sat8(x - TBL[m][2] * (cr - 512) - TBL[m][3] * (cb - 512), cg_c);
    o.b = sat8(x + TBL[m][4] * (cb - 512), cb_c);
    o.sof = sof;
    o.eol = eol;
    o.clip = cr_c || cg_c || cb_c;
    return o;
  endfunction
  task automatic send(input int y, input int cb, input int cr, input bit sof, input bit eol,
                      input int md);
    s_y = IN_W'(y); s_cb = IN_W'(cb); s_cr = IN_W'(cr);
    s_sof = sof; s_eol = eol; mode = 2'(md); s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        if (sof) act_mode = md;
        q.push_back(ref_px(y, cb, cr, act_mode, sof, eol));
        @(posedge clk); #1;
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask
  task automatic lat_check();
    @(negedge clk); chk("lat_c1_valid", m_valid, 0);
    @(negedge clk); chk("lat_c2_valid", m_valid, 0);
    @(negedge clk); chk("lat_c3_valid", m_valid, 1);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask
  always @(posedge clk) begin
    #1;
    m_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        chk("stall_hold", int'({m_r, m_g, m_b, m_sof, m_eol, m_clip}), held);
        chk("stall_valid", m_valid, 1);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("r", m_r, e.r);
          chk("g", m_g, e.g);
          chk("b", m_b, e.b);
          chk("sof", m_sof, e.sof);
          chk("eol", m_eol, e.eol);
          chk("clip", m_clip, e.clip);
          chk("clip_cnt", clip_cnt, cnt_m);
          if (e.sof) begin
            cnt_m = run_m;
            run_m = e.clip;
          end else if (e.clip) run_m++;
        end
      end
      hold = m_valid && !m_ready;
      held = int'({m_r, m_g, m_b, m_sof, m_eol, m_clip});
    end else hold = 1'b0;
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_clip_cnt", clip_cnt, 0);
    chk("rst_rgb", int'({m_r, m_g, m_b}), 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(64, 512, 512, 1, 0, 0);
    lat_check();
    send(940, 512, 512, 0, 1, 1);
    for (int i = 0; i < 10; i++) send(1023, 512, 1023, i == 0, i == 9, 0);
    send(940, 512, 512, 1, 0, 0);
    drain();
    chk("clip_cnt_frame", clip_cnt, 10);
    send(940, 512, 1023, 0, 0, 1);
    send(940, 512, 512, 1, 0, 1);
    send(940, 512, 1023, 0, 0, 2);
    send(1023, 512, 1023, 0, 1, 0);
    drain();
    stall_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
           i % 25 == 0, i % 10 == 9, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    stall_en = 1'b0;
    @(posedge clk); #1;
    send(700, 300, 800, 1, 0, 3);
    send(100, 900, 200, 0, 0, 0);
    send(800, 512, 1000, 0, 1, 2);
    rst = 1'b1;
    q.delete();
    act_mode = 0; run_m = 0; cnt_m = 0;
    @(negedge clk);
    chk("rst2_m_valid", m_valid, 0);
    chk("rst2_clip_cnt", clip_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(940, 512, 1023, 0, 0, 3);
    lat_check();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
